m_pcpi_dispatch: RTL and testbench
==================================

// Module: m_pcpi_dispatch
// PURPOSE
// Upstream issue stage between the core's PCPI port and the M-extension unit.
// Decodes RV32M instructions, latches instruction/operands, and holds them stable toward the M unit.
// Captures the M unit's result and returns it to the core as a one-cycle response.
// Adds a completion timeout and abort handling so a hung or cancelled operation never wedges the core.
// PARAMETERS
// TIMEOUT_CYCLES  64  max cycles in BUSY before a forced error response (>=2)
// ENABLE_DIV      1   1: claim MUL* and DIV/REM*; 0: claim only funct3[2]==0 (MUL/MULH/MULHSU/MULHU)
// PORTS
// clk            in   1   clock, all state on rising edge
// rst            in   1   reset, asynchronous, active-high
// pcpi_valid     in   1   core: instruction offered, held until pcpi_ready or abort
// pcpi_insn      in   32  core: instruction word
// pcpi_rs1       in   32  core: operand rs1
// pcpi_rs2       in   32  core: operand rs2
// pcpi_wr        out  1   core: write rd this response
// pcpi_rd        out  32  core: result
// pcpi_wait      out  1   core: instruction claimed, result pending
// pcpi_ready     out  1   core: response valid (1-cycle pulse)
// m_valid        out  1   M unit: request valid, held until m_ready
// m_instruction  out  32  M unit: latched instruction
// m_rs1          out  32  M unit: latched rs1
// m_rs2          out  32  M unit: latched rs2
// m_wr           in   1   M unit: write enable of result
// m_rd           in   32  M unit: result
// m_busy         in   1   M unit: operation in progress
// m_ready        in   1   M unit: result valid this cycle
// timeout_err    out  1   sticky: a timeout response was issued; cleared only by rst
// BEHAVIOUR
// - Reset: state IDLE, counter 0, latches 0; every output 0 asynchronously (incl. mid-operation).
// - All outputs are registered or decoded from state/registers only; no comb path from pcpi_* to outputs.
// - Claim: pcpi_insn[6:0]==7'b0110011 && [31:25]==7'b0000001 && (ENABLE_DIV || !pcpi_insn[14]).
// - FSM IDLE: pcpi_valid && claim -> latch insn/rs1/rs2, clear counter, ->BUSY. Unclaimed -> stay, no outputs.
// - BUSY: m_valid=1, pcpi_wait=1. Operands are frozen.
//   - m_ready: capture m_wr/m_rd -> RESP.
//   - Else, if counter==TIMEOUT_CYCLES-1: -> RESP with wr=0, rd=0, and set timeout_err.
//   - Else, if pcpi_valid==0 (core abort): -> DRAIN, no response.
//   - Else: counter+1.
//   - Priority: m_ready > timeout > abort.
// - RESP: exactly 1 cycle. pcpi_ready=1, pcpi_wr/pcpi_rd = captured values, m_valid=0, pcpi_wait=0; ->DRAIN.
// - DRAIN: all handshake outputs 0. ->IDLE once pcpi_valid==0 && m_busy==0.
//   Prevents re-issue of the same instruction and overlap with an unfinished M op.
// - Latency: accept at cycle 0; m_valid from cycle 1; m_ready at cycle k -> pcpi_ready at k+1.
//   Max BUSY length is TIMEOUT_CYCLES cycles.
// - pcpi_rd=0 and pcpi_wr=0 whenever pcpi_ready=0.
// - Counter width is $clog2(TIMEOUT_CYCLES); the counter never wraps.
// TESTING
// - MUL x10,x10,x11 (0x02B50533), rs1=6, rs2=7; model m_ready 3 cycles after m_valid with rd=42, wr=1
//   -> m_instruction=0x02B50533, m_rs1=6, m_rs2=7; one-cycle pcpi_ready with wr=1, rd=42; pcpi_wait high until then.
// - ADD 0x00B50533 with pcpi_valid=1 for 10 cycles -> m_valid, pcpi_wait, pcpi_ready all stay 0.
// - DIV 0x02B54533: ENABLE_DIV=0 -> ignored. ENABLE_DIV=1, rs1=100, rs2=7, model rd=14 -> pcpi_rd=14.
// - TIMEOUT_CYCLES=8, m_ready never asserted -> pcpi_ready at cycle 9 after accept, wr=0, rd=0; timeout_err=1 stays set.
//   m_ready in the final BUSY cycle -> normal result and timeout_err stays 0.
// - Abort: drop pcpi_valid on BUSY cycle 3 while m_busy=1 for 4 more cycles
//   -> m_valid=0 next cycle, no pcpi_ready; IDLE only after m_busy falls; next MUL is accepted normally.
// - Assert rst mid-BUSY -> all outputs 0 in the same cycle; after release, a back-to-back MUL then MULHU both complete correctly.

Source files
------------

// File: rtl/m_pcpi_dispatch.sv
// PCPI issue stage for the RV32M unit: decodes and claims M instructions, holds
// operands toward the M unit, and returns a one-cycle response with timeout/abort recovery.
module m_pcpi_dispatch #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned ENABLE_DIV     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic        m_valid,
  output logic [31:0] m_instruction,
  output logic [31:0] m_rs1,
  output logic [31:0] m_rs2,
  input  logic        m_wr,
  input  logic [31:0] m_rd,
  input  logic        m_busy,
  input  logic        m_ready,
  output logic        timeout_err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, DRAIN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             claim;

  assign claim = (pcpi_insn[6:0] == 7'b0110011) && (pcpi_insn[31:25] == 7'b0000001) &&
                 ((ENABLE_DIV != 0) || !pcpi_insn[14]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      m_instruction <= '0;
      m_rs1         <= '0;
      m_rs2         <= '0;
      m_valid       <= 1'b0;
      pcpi_wait     <= 1'b0;
      pcpi_ready    <= 1'b0;
      pcpi_wr       <= 1'b0;
      pcpi_rd       <= '0;
      timeout_err   <= 1'b0;
    end else begin
      // response fields are only non-zero during the single RESP cycle
      pcpi_ready <= 1'b0;
      pcpi_wr    <= 1'b0;
      pcpi_rd    <= '0;
      unique case (state)
        IDLE: begin
          if (pcpi_valid && claim) begin
            m_instruction <= pcpi_insn;
            m_rs1         <= pcpi_rs1;
            m_rs2         <= pcpi_rs2;
            cnt           <= '0;
            m_valid       <= 1'b1;
            pcpi_wait     <= 1'b1;
            state         <= BUSY;
          end
        end
        BUSY: begin
          if (m_ready) begin
            m_valid    <= 1'b0;
            pcpi_wait  <= 1'b0;
            pcpi_ready <= 1'b1;
            pcpi_wr    <= m_wr;
            pcpi_rd    <= m_rd;
            state      <= RESP;
          end else if (cnt == CNT_LAST) begin
            m_valid     <= 1'b0;
            pcpi_wait   <= 1'b0;
            pcpi_ready  <= 1'b1;
            timeout_err <= 1'b1;
            state       <= RESP;
          end else if (!pcpi_valid) begin
            m_valid   <= 1'b0;
            pcpi_wait <= 1'b0;
            state     <= DRAIN;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: state <= DRAIN;
        DRAIN: begin
          // wait for the core to drop the request and the M unit to go quiet
          if (!pcpi_valid && !m_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m_pcpi_dispatch.sv
// Self-checking bench for m_pcpi_dispatch: vector table, randomized transactions,
// abort and reset sequences, checked against a transaction-level latency model.
module tb_m_pcpi_dispatch;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic        pcpi_wr, pcpi_wait, pcpi_ready, m_valid, timeout_err;
  logic [31:0] pcpi_rd, m_instruction, m_rs1, m_rs2;
  logic        m_wr, m_busy, m_ready;
  logic [31:0] m_rd;
  logic        b_wr, b_wait, b_ready, b_valid, b_terr;
  logic [31:0] b_rd, b_insn, b_rs1, b_rs2;

  int n_chk = 0;
  int n_fail = 0;
  logic exp_terr = 1'b0;

  always #5 clk = ~clk;

  m_pcpi_dispatch #(.TIMEOUT_CYCLES(TO), .ENABLE_DIV(1)) dut (
    .clk(clk), .rst(rst), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
    .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready), .m_valid(m_valid),
    .m_instruction(m_instruction), .m_rs1(m_rs1), .m_rs2(m_rs2), .m_wr(m_wr),
    .m_rd(m_rd), .m_busy(m_busy), .m_ready(m_ready), .timeout_err(timeout_err));

  m_pcpi_dispatch #(.TIMEOUT_CYCLES(TO), .ENABLE_DIV(0)) dut_nodiv (
    .clk(clk), .rst(rst), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_wr(b_wr), .pcpi_rd(b_rd),
    .pcpi_wait(b_wait), .pcpi_ready(b_ready), .m_valid(b_valid),
    .m_instruction(b_insn), .m_rs1(b_rs1), .m_rs2(b_rs2), .m_wr(m_wr),
    .m_rd(m_rd), .m_busy(m_busy), .m_ready(m_ready), .timeout_err(b_terr));

  typedef struct {
    logic [31:0] insn;
    logic [31:0] rs1;
    logic [31:0] rs2;
    int          delay;  // cycle after accept in which m_ready is raised
    logic [31:0] rd;
    logic        wr;
    int          hold;   // cycles the core offers an unclaimed instruction
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_m(input logic [31:0] insn);
    return (insn[6:0] == 7'h33) && (insn[31:25] == 7'h01);
  endfunction

  task automatic idle_outputs(input string tag);
    chk({tag, " m_valid"}, 32'(m_valid), 32'd0);
    chk({tag, " pcpi_wait"}, 32'(pcpi_wait), 32'd0);
    chk({tag, " pcpi_ready"}, 32'(pcpi_ready), 32'd0);
    chk({tag, " pcpi_rd"}, pcpi_rd, 32'd0);
  endtask

  task automatic run_txn(input vec_t v);
    bit c1, c2, tmo;
    int r;
    logic [31:0] erd;
    logic ewr;
    c1 = is_m(v.insn);
    c2 = c1 && !v.insn[14];
    pcpi_valid = 1'b1; pcpi_insn = v.insn; pcpi_rs1 = v.rs1; pcpi_rs2 = v.rs2;
    m_ready = 1'b0; m_busy = 1'b0; m_wr = 1'b0; m_rd = 32'd0;
    if (!c1) begin
      for (int n = 1; n <= v.hold; n++) begin
        tick();
        idle_outputs("unclaimed");
        chk("unclaimed nodiv m_valid", 32'(b_valid), 32'd0);
      end
      pcpi_valid = 1'b0;
      tick();
      return;
    end
    tmo = (v.delay > TO);
    r   = tmo ? TO + 1 : v.delay + 1;
    erd = tmo ? 32'd0 : v.rd;
    ewr = tmo ? 1'b0 : v.wr;
    for (int n = 1; n <= r; n++) begin
      tick();
      if (n == r && tmo) exp_terr = 1'b1;
      chk("m_valid", 32'(m_valid), 32'(n < r));
      chk("pcpi_wait", 32'(pcpi_wait), 32'(n < r));
      chk("pcpi_ready", 32'(pcpi_ready), 32'(n == r));
      chk("pcpi_wr", 32'(pcpi_wr), (n == r) ? 32'(ewr) : 32'd0);
      chk("pcpi_rd", pcpi_rd, (n == r) ? erd : 32'd0);
      chk("timeout_err", 32'(timeout_err), 32'(exp_terr));
      chk("nodiv m_valid", 32'(b_valid), 32'(c2 && n < r));
      if (n < r) begin
        chk("m_instruction", m_instruction, v.insn);
        chk("m_rs1", m_rs1, v.rs1);
        chk("m_rs2", m_rs2, v.rs2);
      end
      // M unit model: garbage on m_rd/m_wr except in the m_ready cycle
      m_ready = (n == v.delay);
      m_busy  = (n < v.delay);
      m_rd    = (n == v.delay) ? v.rd : $urandom;
      m_wr    = (n == v.delay) ? v.wr : 1'($urandom);
      if (n == r) begin
        pcpi_valid = 1'b0; m_ready = 1'b0; m_busy = 1'b0;
      end
    end
    tick();
    idle_outputs("drain");
    tick();
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    rst = 1'b1; pcpi_valid = 1'b0; pcpi_insn = 32'd0; pcpi_rs1 = 32'd0; pcpi_rs2 = 32'd0;
    m_wr = 1'b0; m_rd = 32'd0; m_busy = 1'b0; m_ready = 1'b0;
    tick(); tick();
    idle_outputs("reset");
    chk("reset m_instruction", m_instruction, 32'd0);
    chk("reset timeout_err", 32'(timeout_err), 32'd0);
    rst = 1'b0;
    tick();

    tbl.push_back('{32'h02B50533, 32'd6,   32'd7, 4,   32'd42,        1'b1, 0});
    tbl.push_back('{32'h00B50533, 32'd1,   32'd2, 0,   32'd0,         1'b0, 10});
    tbl.push_back('{32'h02B54533, 32'd100, 32'd7, 2,   32'd14,        1'b1, 0});
    tbl.push_back('{32'h02B53533, 32'hFFFF_FFFF, 32'h2, 1, 32'h1,     1'b1, 0});
    tbl.push_back('{32'h02B56533, 32'd9,   32'd4, 5,   32'h0000_DEAD, 1'b0, 0});
    tbl.push_back('{32'h02B50513, 32'd3,   32'd3, 0,   32'd0,         1'b0, 4});
    tbl.push_back('{32'h02B50533, 32'd5,   32'd5, TO,  32'h0000_1234, 1'b1, 0});
    tbl.push_back('{32'h02B50533, 32'd8,   32'd8, 999, 32'h5555_5555, 1'b1, 0});
    tbl.push_back('{32'h02B51533, 32'd2,   32'd3, 3,   32'hCAFE_0001, 1'b1, 0});
    foreach (tbl[i]) run_txn(tbl[i]);

    for (int i = 0; i < 40; i++) begin
      v.insn = $urandom;
      if ($urandom_range(0, 4) != 0) v.insn[6:0] = 7'h33;
      if ($urandom_range(0, 3) != 0) v.insn[31:25] = 7'h01;
      v.rs1 = $urandom; v.rs2 = $urandom;
      v.delay = $urandom_range(1, TO + 3);
      v.rd = $urandom; v.wr = 1'($urandom); v.hold = 3;
      run_txn(v);
    end

    // core abort while the M unit is still busy
    pcpi_valid = 1'b1; pcpi_insn = 32'h02B50533; pcpi_rs1 = 32'd1; pcpi_rs2 = 32'd1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (n > 3) begin
        idle_outputs("abort");
      end else begin
        chk("abort busy m_valid", 32'(m_valid), 32'd1);
      end
      pcpi_valid = (n <= 2) || (n == 5) || (n == 6);
      m_busy     = (n >= 3) && (n <= 6);
    end
    v = '{32'h02B50533, 32'd11, 32'd12, 2, 32'd132, 1'b1, 0};
    run_txn(v);

    // reset in the middle of BUSY clears everything, including the sticky error
    pcpi_valid = 1'b1; pcpi_insn = 32'h02B50533; pcpi_rs1 = 32'd3; pcpi_rs2 = 32'd4;
    tick(); tick();
    chk("pre-reset m_valid", 32'(m_valid), 32'd1);
    rst = 1'b1;
    #1;
    idle_outputs("midreset");
    chk("midreset m_instruction", m_instruction, 32'd0);
    chk("midreset m_rs1", m_rs1, 32'd0);
    chk("midreset timeout_err", 32'(timeout_err), 32'd0);
    exp_terr = 1'b0;
    pcpi_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    v = '{32'h02B50533, 32'd6, 32'd7, 3, 32'd42, 1'b1, 0};
    run_txn(v);
    v = '{32'h02B53533, 32'h8000_0000, 32'd4, 2, 32'd2, 1'b1, 0};
    run_txn(v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
